dmem_loader: RTL and testbench

- Test and bring-up harness block. It streams a word array into the core's data memory while holding the core in reset.
- It then releases the core for a fixed cycle budget, freezes it again, and streams the same address range back out for checking.
- It is the writer/loader counterpart to the end-of-run data-memory readback. It sits between an external word stream and the dmem write/read port, and it owns the core reset.

---
 rtl/dmem_loader.sv | 147 ++++++++++++++
 tb/tb_dmem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_loader.sv
// Bring-up harness: loads a word stream into data memory with the core held in reset,
// runs the core for a fixed budget, then streams the same address range back out.
module dmem_loader #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int RUN_CYCLES  = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int MAX_CYCLES = (HOLD_CYCLES > RUN_CYCLES) ? HOLD_CYCLES : RUN_CYCLES;
    // The shared phase counter only ever holds (cycles - 1).
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    HOLD_TOP = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    RUN_TOP  = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DUMP, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_WIDTH:0] word_count_reg, word_count_next;
    logic [ADDR_WIDTH:0] dump_idx_reg, dump_idx_next;
    logic                overflow_reg, overflow_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            word_count_reg <= '0;
            dump_idx_reg   <= '0;
            overflow_reg   <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            word_count_reg <= word_count_next;
            dump_idx_reg   <= dump_idx_next;
            overflow_reg   <= overflow_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        word_count_next = word_count_reg;
        dump_idx_next   = dump_idx_reg;
        overflow_next   = overflow_reg;
        cnt_next        = cnt_reg;
        s_ready         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        m_valid         = 1'b0;
        m_data          = '0;
        m_last          = 1'b0;
        core_rst        = 1'b1;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    state_next      = LOAD;
                    word_count_next = '0;
                    overflow_next   = 1'b0;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    mem_we          = 1'b1;
                    mem_addr        = word_count_reg[ADDR_WIDTH-1:0];
                    mem_wdata       = s_data;
                    word_count_next = word_count_reg + IDX_ONE;
                    // Filling the last slot without s_last ends the load as an overflow.
                    if (s_last || word_count_reg == LAST_IDX) begin
                        state_next    = HOLD;
                        cnt_next      = HOLD_TOP;
                        overflow_next = !s_last;
                    end
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = RUN;
                    cnt_next   = RUN_TOP;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                if (cnt_reg == '0) begin
                    state_next    = DUMP;
                    dump_idx_next = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            DUMP: begin
                busy     = 1'b1;
                mem_addr = dump_idx_reg[ADDR_WIDTH-1:0];
                m_valid  = 1'b1;
                m_data   = mem_rdata;
                m_last   = (dump_idx_reg == word_count_reg - IDX_ONE);
                if (m_ready) begin
                    if (m_last) begin
                        state_next = DONE;
                    end else begin
                        dump_idx_next = dump_idx_reg + IDX_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign overflow   = overflow_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: a sorting "core" model owns memory during RUN,
// and a scoreboard checks every write, the run window and every dump word.
module tb_dmem_loader;
    localparam int DW     = 16;
    localparam int AW     = 4;
    localparam int HOLD   = 2;
    localparam int RUN    = 10;
    localparam int AW_B   = 2;
    localparam int HOLD_B = 1;
    localparam int RUN_B  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          start, s_valid, s_last, s_ready, mem_we, m_valid, m_last, m_ready;
    logic          core_rst, busy, done, overflow;
    logic [DW-1:0] s_data, mem_wdata, mem_rdata, m_data;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   word_count;

    logic            start_b, s_valid_b, s_last_b, s_ready_b, mem_we_b, m_valid_b, m_last_b, m_ready_b;
    logic            core_rst_b, busy_b, done_b, overflow_b;
    logic [DW-1:0]   s_data_b, mem_wdata_b, mem_rdata_b, m_data_b;
    logic [AW_B-1:0] mem_addr_b;
    logic [AW_B:0]   word_count_b;

    dmem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLD_CYCLES(HOLD), .RUN_CYCLES(RUN)) dut_a (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .core_rst(core_rst), .busy(busy), .done(done),
        .overflow(overflow), .word_count(word_count)
    );

    dmem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_B), .HOLD_CYCLES(HOLD_B), .RUN_CYCLES(RUN_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_data(s_data_b), .s_last(s_last_b),
        .s_ready(s_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b),
        .m_ready(m_ready_b), .core_rst(core_rst_b), .busy(busy_b), .done(done_b),
        .overflow(overflow_b), .word_count(word_count_b)
    );

    // Memories; the core model replaces the loaded words with their sorted order on its first run cycle.
    logic [DW-1:0] mem_a    [0:2**AW-1];
    logic [DW-1:0] core_img [0:2**AW-1];
    logic [DW-1:0] mem_b    [0:2**AW_B-1];
    int            core_n = 0;
    logic          core_prev;
    assign mem_rdata   = mem_a[mem_addr];
    assign mem_rdata_b = mem_b[mem_addr_b];

    always @(posedge clk) begin
        core_prev <= core_rst;
        if (mem_we) mem_a[mem_addr] <= mem_wdata;
        else if (!core_rst && core_prev)
            for (int i = 0; i < 2**AW; i++) if (i < core_n) mem_a[i] <= core_img[i];
        if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks = 0;
    int            errors = 0;
    int            exp_addr[$];
    int            exp_data[$];
    int            exp_dump[$];
    logic [DW-1:0] dump_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // Compare process: every write, the run window and every dump word.
    initial begin : compare
        int            run_len;
        int            last_wr_cyc;
        bit            stall_prev;
        logic [DW-1:0] stall_data;
        run_len = 0; last_wr_cyc = 0; stall_prev = 0; stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0;
                stall_prev = 0;
            end else begin
                chk("busy_done_exclusive", busy & done, 0);
                if (mem_we) begin
                    $display("cyc %0d write addr=%0d data=%0h", cyc, mem_addr, mem_wdata);
                    chk("wr_core_rst", core_rst, 1);
                    if (exp_addr.size() == 0) fail_now("wr_unexpected", mem_addr);
                    else begin
                        chk("wr_addr", mem_addr, exp_addr.pop_front());
                        chk("wr_data", mem_wdata, exp_data.pop_front());
                    end
                    last_wr_cyc = cyc;
                end
                if (!core_rst) begin
                    if (run_len == 0) chk("run_start_gap", cyc - last_wr_cyc, HOLD + 1);
                    chk("run_busy", busy, 1);
                    run_len++;
                end else if (run_len != 0) begin
                    chk("run_len", run_len, RUN);
                    run_len = 0;
                end
                if (m_valid) begin
                    chk("dump_core_rst", core_rst, 1);
                    if (stall_prev) chk("dump_stable", m_data, stall_data);
                    if (m_ready) begin
                        $display("cyc %0d dump data=%0h last=%0b", cyc, m_data, m_last);
                        if (exp_dump.size() == 0) fail_now("dump_unexpected", m_data);
                        else begin
                            chk("dump_data", m_data, exp_dump.pop_front());
                            chk("dump_last", m_last, exp_dump.size() == 0);
                        end
                        dump_log.push_back(m_data);
                        stall_prev = 0;
                    end else begin
                        stall_prev = 1;
                        stall_data = m_data;
                    end
                end else if (stall_prev) begin
                    fail_now("dump_valid_dropped", m_valid);
                    stall_prev = 0;
                end
            end
        end
    end

    task automatic prep(input int vals[$]);
        int srt[$];
        srt = vals;
        srt.sort();
        exp_dump = srt;
        core_n = srt.size();
        for (int i = 0; i < srt.size(); i++) core_img[i] = DW'(srt[i]);
        for (int i = 0; i < vals.size(); i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(vals[i]);
        end
        dump_log.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_clears_wc", word_count, 0);
        chk("start_clears_ovf", overflow, 0);
        chk("start_busy", busy, 1);
        @(posedge clk); #1;
    endtask

    task automatic load_a(input int vals[$], input int gaps[$], input int pulse_at);
        int t;
        for (int i = 0; i < vals.size(); i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                s_valid = 1'b0;
                start = (i == pulse_at && g == 0);
                @(negedge clk);
                chk("gap_s_ready", s_ready, 1);
                @(posedge clk); #1;
                start = 1'b0;
            end
            s_valid = 1'b1;
            s_data  = DW'(vals[i]);
            s_last  = (i == vals.size() - 1);
            t = 0;
            @(negedge clk);
            while (!s_ready && t < 20) begin @(negedge clk); t++; end
            chk("load_accept", s_ready, 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic finish_a(input int n, input bit [3:0] pat, input bit pulse_dump);
        int t;
        bit pulsed;
        t = 0; pulsed = 0;
        while (t < 600) begin
            @(posedge clk); #1;
            if (done) break;
            start = 1'b0;
            if (pulse_dump && m_valid && !pulsed) begin start = 1'b1; pulsed = 1; end
            m_ready = pat[t % 4];
            t++;
        end
        start = 1'b0;
        m_ready = 1'b1;
        chk("done_reached", done, 1);
        chk("end_busy", busy, 0);
        chk("end_core_rst", core_rst, 1);
        chk("end_word_count", word_count, n);
        chk("dump_remaining", exp_dump.size(), 0);
        chk("write_remaining", exp_addr.size(), 0);
        chk("dump_count", dump_log.size(), n);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

    initial begin : main
        int t;
        int k;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        start_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; s_last_b = 1'b0; m_ready_b = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic sequence, sorted by the core model during RUN.
        prep('{5, 4, 3, 2, 1});
        pulse_start();
        load_a('{5, 4, 3, 2, 1}, '{0, 0, 0, 0, 0}, -1);
        finish_a(5, 4'b1111, 1'b0);
        if (dump_log.size() == 5) begin
            chk("t1_first_dump", dump_log[0], 1);
            chk("t1_last_dump", dump_log[4], 5);
        end

        // Restart from DONE, gapped stream, start pulsed in LOAD and DUMP, stalled dump.
        prep('{9, 7, 8, 6, 10});
        pulse_start();
        load_a('{9, 7, 8, 6, 10}, '{0, 1, 3, 2, 0}, 2);
        finish_a(5, 4'b1001, 1'b1);
        if (dump_log.size() == 5) begin
            chk("t2_first_dump", dump_log[0], 6);
            chk("t2_last_dump", dump_log[4], 10);
        end

        // Minimum load of a single word.
        prep('{42});
        pulse_start();
        load_a('{42}, '{0}, -1);
        finish_a(1, 4'b1111, 1'b0);
        if (dump_log.size() == 1) chk("t3_dump", dump_log[0], 42);

        // Asynchronous reset on the fifth RUN cycle, then a fresh sequence from address 0.
        prep('{3, 1, 2});
        pulse_start();
        load_a('{3, 1, 2}, '{0, 0, 0}, -1);
        t = 0;
        while (core_rst && t < 50) begin @(posedge clk); #1; t++; end
        chk("t4_run_reached", core_rst, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_core_rst", core_rst, 1);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_wc", word_count, 0);
        chk("t4_rst_m_valid", m_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        exp_dump.delete();
        prep('{8, 6});
        pulse_start();
        load_a('{8, 6}, '{0, 0}, -1);
        finish_a(2, 4'b1111, 1'b0);
        if (dump_log.size() == 2) chk("t4_dump", dump_log[0], 6);

        // Overflow on the small instance: five words into four slots, no s_last.
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid_b = 1'b1;
            s_data_b  = DW'(100 + i);
            @(negedge clk);
            chk("ovf_s_ready", s_ready_b, i < 4);
            chk("ovf_we", mem_we_b, i < 4);
            if (i < 4) begin
                $display("cyc %0d ovf write addr=%0d data=%0h", cyc, mem_addr_b, mem_wdata_b);
                chk("ovf_addr", mem_addr_b, i);
                chk("ovf_data", mem_wdata_b, 100 + i);
            end
            @(posedge clk); #1;
        end
        s_valid_b = 1'b0;
        chk("ovf_flag", overflow_b, 1);
        chk("ovf_wc", word_count_b, 4);
        k = 0; t = 0;
        while (!done_b && t < 100) begin
            @(negedge clk);
            if (m_valid_b) begin
                $display("cyc %0d ovf dump data=%0h last=%0b", cyc, m_data_b, m_last_b);
                chk("ovf_dump_data", m_data_b, 100 + k);
                chk("ovf_dump_last", m_last_b, k == 3);
                k++;
            end
            @(posedge clk); #1;
            t++;
        end
        chk("ovf_dump_count", k, 4);
        chk("ovf_done", done_b, 1);
        chk("ovf_sticky", overflow_b, 1);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow_b, 0);
        chk("ovf_wc_cleared", word_count_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
